// File: rtl/lau_pkg.sv
// Shared types for the long-arithmetic unit: adder speed selection and
// the multi-word sequencer state encoding.
package lau_pkg;

    typedef enum logic [1:0] {
        SLOW,
        MEDIUM,
        FAST
    } speed_e;

    typedef enum logic {
        FIRST,
        CHAIN
    } addmw_state_e;

endpackage

// File: rtl/add_multiword_seq_addcfast.sv
// AddCfast: combinational width-bit adder slice, {CO,S} = A + B + CI.
// SLOW builds an explicit ripple chain; other speeds leave the structure to synthesis.
module AddCfast
    import lau_pkg::*;
#(
    parameter int     width = 32,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    output logic [width-1:0] S,
    output logic             CO
);

    generate
        if (speed == SLOW) begin : g_ripple
            logic [width:0] w_c;

            always_comb begin
                w_c    = '0;
                S      = '0;
                w_c[0] = CI;
                for (int i = 0; i < width; i++) begin
                    S[i]     = A[i] ^ B[i] ^ w_c[i];
                    w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
                end
            end

            assign CO = w_c[width];
        end else begin : g_behav
            assign {CO, S} = {1'b0, A} + {1'b0, B} + {{width{1'b0}}, CI};
        end
    endgenerate

endmodule

// File: rtl/add_multiword_seq.sv
// Sequential multi-word adder: streams operands LSW first through one AddCfast
// slice, chaining carries across words. ADD_MULTIWORD_OVF_EN adds overflow output V.
//
// state | meaning
// FIRST | next accepted word is word 0; adder carry-in comes from CI
// CHAIN | words 1..words-1; adder carry-in comes from the carry register
module add_multiword_seq
    import lau_pkg::*;
#(
    parameter int     width = 32,
    parameter int     words = 4,
    parameter speed_e speed = FAST
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [width-1:0] S,
    output logic             Last,
    output logic             CO
`ifdef ADD_MULTIWORD_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CW = (words > 1) ? $clog2(words) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(words - 1);

    addmw_state_e     r_state;
    addmw_state_e     w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_carry;
    logic             r_valid;
    logic [width-1:0] r_s;
    logic             r_last;
    logic             r_co;

    logic             w_accept;
    logic             w_last;
    logic             w_cin;
    logic [width-1:0] w_s;
    logic             w_co;

    assign InReady  = ~RST & (~r_valid | OutReady);
    assign w_accept = InValid & InReady;
    assign w_last   = (r_cnt == LAST_CNT);

    AddCfast #(
        .width (width),
        .speed (speed)
    ) u_slice (
        .A  (A),
        .B  (B),
        .CI (w_cin),
        .S  (w_s),
        .CO (w_co)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FIRST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cin       = (r_state == FIRST) ? CI : r_carry;
        if (w_accept) begin
            if (w_last) begin
                w_state_nxt = FIRST;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = CHAIN;
                w_cnt_nxt   = r_cnt + CW'(1);
            end
        end
    end

    // Carry and result only move on accept, so a stalled output never disturbs the chain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_carry <= 1'b0;
            r_valid <= 1'b0;
            r_s     <= '0;
            r_last  <= 1'b0;
            r_co    <= 1'b0;
        end else if (w_accept) begin
            r_carry <= w_co;
            r_valid <= 1'b1;
            r_s     <= w_s;
            r_last  <= w_last;
            r_co    <= w_co & w_last;
        end else if (OutReady) begin
            r_valid <= 1'b0;
        end
    end

`ifdef ADD_MULTIWORD_OVF_EN
    logic r_v;
    logic w_msb_cin;

    assign w_msb_cin = A[width-1] ^ B[width-1] ^ w_s[width-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v <= 1'b0;
        end else if (w_accept) begin
            r_v <= w_last & (w_msb_cin ^ w_co);
        end
    end

    assign V = r_v;
`endif

    assign OutValid = r_valid;
    assign S        = r_s;
    assign Last     = r_last;
    assign CO       = r_co;

endmodule

// File: tb/tb_add_multiword_seq.sv
// Directed + randomized bench for add_multiword_seq (width=8, words=4); expected
// words come from full-width arithmetic on the whole operands.
module tb_add_multiword_seq;

    localparam int W  = 8;
    localparam int NW = 4;
    localparam int FW = W * NW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          InValid;
    logic          InReady;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          CI;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  S;
    logic          Last;
    logic          CO;
`ifdef ADD_MULTIWORD_OVF_EN
    logic          V;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    add_multiword_seq #(
        .width (W),
        .words (NW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .CI       (CI),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .S        (S),
        .Last     (Last),
        .CO       (CO)
`ifdef ADD_MULTIWORD_OVF_EN
        ,
        .V        (V)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams nw words of one operation; if stall_k is in 1..NW-1, OutReady is
    // dropped for 3 cycles while word stall_k is waiting to be accepted.
    task automatic run_op(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic ci,
                          input int stall_k, input int nw);
        logic [FW:0] e;
        logic        exp_v;
        e     = {1'b0, a} + {1'b0, b} + {{FW{1'b0}}, ci};
        exp_v = (a[FW-1] == b[FW-1]) && (e[FW-1] != a[FW-1]);
        for (int k = 0; k < nw; k++) begin
            InValid = 1'b1;
            A       = a[k*W +: W];
            B       = b[k*W +: W];
            CI      = (k == 0) ? ci : 1'($urandom_range(0, 1));
            if (k == stall_k && k > 0) begin
                OutReady = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge CLK);
                    chk("stall_inready", 64'(InReady), 64'd0);
                    chk("stall_valid", 64'(OutValid), 64'd1);
                    chk("stall_s", 64'(S), 64'(e[(k-1)*W +: W]));
                    @(posedge CLK);
                    #1;
                end
                OutReady = 1'b1;
            end
            @(negedge CLK);
            chk("inready", 64'(InReady), 64'd1);
            @(posedge CLK);
            #1;
            chk("valid", 64'(OutValid), 64'd1);
            chk("sum_word", 64'(S), 64'(e[k*W +: W]));
            chk("last", 64'(Last), 64'(k == NW - 1));
            chk("co", 64'(CO), (k == NW - 1) ? 64'(e[FW]) : 64'd0);
`ifdef ADD_MULTIWORD_OVF_EN
            chk("ovf", 64'(V), (k == NW - 1) ? 64'(exp_v) : 64'd0);
`endif
        end
    endtask

    initial begin
        RST      = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        A        = '0;
        B        = '0;
        CI       = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", 64'(OutValid), 64'd0);
        chk("rst_s", 64'(S), 64'd0);
        chk("rst_last", 64'(Last), 64'd0);
        chk("rst_co", 64'(CO), 64'd0);
        chk("rst_inready", 64'(InReady), 64'd0);
`ifdef ADD_MULTIWORD_OVF_EN
        chk("rst_v", 64'(V), 64'd0);
`endif
        RST = 1'b0;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, NW);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, -1, NW);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, NW);

        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, -1, 2);
        RST     = 1'b1;
        InValid = 1'b0;
        @(posedge CLK);
        #1;
        chk("midrst_valid", 64'(OutValid), 64'd0);
        chk("midrst_s", 64'(S), 64'd0);
        RST = 1'b0;
        run_op(32'h4030_2010, 32'h0403_0201, 1'b0, -1, NW);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, NW);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, -1, NW);

        run_op(32'h7F00_0000, 32'h0100_0000, 1'b0, -1, NW);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, NW);

        for (int i = 0; i < 24; i++) begin
            run_op(FW'($urandom), FW'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NW - 1)) : -1, NW);
        end

        InValid = 1'b0;
        @(posedge CLK);
        #1;
        chk("drain_valid", 64'(OutValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/add_multiword_seq.md
# add_multiword_seq

Sequential multi-word adder that streams two long operands word by word (least-significant word first) through a single `AddCfast` slice. It chains the carry-out of each word into the carry-in of the next through a carry register. It sits directly around the combinational adder: it generates the adder's `CI` and consumes its `S` and `CO`, so wide (`width*words`-bit) additions run at one word per cycle with valid/ready flow control.

## Interface
- `width`, 32, word width in bits (>= 2)
- `words`, 4, words per operation (>= 1)
- `speed`, `lau_pkg::FAST`, performance parameter passed to the adder slice
- `CLK  in  1  clock`; all state updates on the rising edge
- `RST  in  1  reset`; synchronous, active-high
- `InValid  in  1  input word valid`
- `InReady  out  1  input word accepted when InValid & InReady`
- `A  in  width  operand A word`
- `B  in  width  operand B word`
- `CI  in  1  carry-in`; sampled only with the first word of an operation
- `OutValid  out  1  result word valid`
- `OutReady  in  1  downstream ready`
- `S  out  width  sum word`
- `Last  out  1  marks the final (most-significant) word of an operation`
- `CO  out  1  final carry-out`; meaningful only when `Last`=1, otherwise 0

## Operation
- States: `FIRST` (word counter = 0) and `CHAIN` (counter 1..words-1).
- Adder carry-in: `CI` in `FIRST`, carry register in `CHAIN`.
- On accept:
  - Carry register <= adder `CO`.
  - Output register <= {`S`, `Last`=(counter==words-1), `CO`=adder `CO` & `Last`}.
  - Counter increments and wraps to 0 after words-1, which returns the block to `FIRST`.
- When `words`=1: always `FIRST`, `Last`=1 on every word, `CI` used every word.
- Carry register and counter change only on accept. Backpressure never corrupts the chain.
- There is no carry leakage between operations: the first word always uses `CI`.
- Arithmetic: each word computes `{CO,S} = A + B + cin`, modulo 2^width. The concatenated output words equal `A_full + B_full + CI` modulo 2^(width*words), with final `CO` as bit width*words.

## Timing
- Latency: 1 cycle from accept to `OutValid`. Throughput: 1 word/cycle sustained.
- `InReady = ~RST & (~OutValid | OutReady)`. This is combinational; the output register is a single-entry pipeline stage.
- `OutValid` stays high, and `S`/`Last`/`CO` stay stable, until `OutReady`.
- Upstream must hold `A`/`B`/`CI` stable while `InValid` is high and `InReady` is low.
- Simultaneous output handshake and new accept in the same cycle: the register reloads and `OutValid` stays 1.
- Reset values: `OutValid`=0, `S`=0, `Last`=0, `CO`=0; counter=0, carry register=0, state `FIRST`.
- Reset mid-operation discards the partial result. The next accepted word is treated as a first word.

## Configuration
- `ADD_MULTIWORD_OVF_EN`
  - Defined: adds output `V  out  1`, the two's-complement overflow of the full-width operation. It is computed on the `Last` word as carry-into-MSB xor `CO`, where carry-into-MSB = `A[width-1]^B[width-1]^S[width-1]`. `V` is registered with `S`, is 0 when `Last`=0, and resets to 0.
  - Undefined: no `V` port and no overflow logic.

## Structure
- `lau_pkg`: existing `speed_e`; add the state enum `addmw_state_e` {`FIRST`, `CHAIN`}.
- Counter width is a local parameter `$clog2(words)` (minimum 1).
- One sub-module: `AddCfast #(width, speed)` instance for the word slice. All registers and the FSM live in this block.

## Test plan
(width=8, words=4; operand words listed LSW first)
- A {FF,FF,FF,FF}, B {01,00,00,00}, CI=0 -> S {00,00,00,00}; `Last` on the 4th word; `CO`=1 on the 4th word.
- A {00,00,00,00}, B {00,00,00,00}, CI=1 -> S {01,00,00,00}, `CO`=0.
- Repeat the first scenario with `OutReady` low for 3 cycles after word 2 -> `InReady` low and outputs held during the stall; final result is identical and no words are lost or duplicated.
- `RST` pulsed after 2 accepted words, then A {10,20,30,40} + B {01,02,03,04}, CI=0 -> `OutValid`=0 the cycle after reset; then S {11,22,33,44}, `CO`=0.
- Back-to-back operations with no bubble: the first scenario followed immediately by A {01,00,00,00} + B {01,00,00,00}, CI=0 -> second result {02,00,00,00}; the carry from operation 1 does not leak into operation 2.
- With `ADD_MULTIWORD_OVF_EN`: A {00,00,00,7F} + B {00,00,00,01}, CI=0 -> S {00,00,00,80}, `V`=1, `CO`=0.
